// File: rtl/exec_sequencer.sv
// ---------------------------------------------------------------------------
// exec_sequencer
//
// Multi-cycle instruction sequencer for a simple load/store core. Walks each
// instruction through FETCH -> DECODE -> EXEC (-> MEM (-> WB)), drives the
// datapath strobes for each step, counts retired instructions and traps into
// a sticky FAULT state when a memory handshake waits too long.
//
// Parameters
//   MEM_TIMEOUT    maximum wait cycles of one memory handshake (1..255)
//
// Ports
//   clk_i          core clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   run_i          start/continue request, looked at on instruction boundaries
//   ig_ex_i        decoder: skip the current instruction
//   br_en_i        decoder: instruction is a branch
//   write_rd_i     decoder: result register must be written
//   s_i            decoder: update condition flags
//   is_mem_i       decoder: single data transfer
//   ld_i           decoder: transfer is a load (1) or store (0)
//   mem_ready_i    memory handshake acknowledge
//   mem_req_o      memory request, held until acknowledged
//   mem_we_o       memory write strobe
//   addr_sel_o     memory address source, 0 = PC, 1 = data address
//   ir_load_o      capture fetched word into IR
//   pc_inc_o       PC += 4
//   pc_load_o      PC <= branch target
//   rf_we_o        register file write enable
//   flags_we_o     NZCV write enable
//   state_o        current state code
//   fault_o        sticky memory-timeout fault
//   instr_count_o  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module exec_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        ig_ex_i,
  input  logic        br_en_i,
  input  logic        write_rd_i,
  input  logic        s_i,
  input  logic        is_mem_i,
  input  logic        ld_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        addr_sel_o,
  output logic        ir_load_o,
  output logic        pc_inc_o,
  output logic        pc_load_o,
  output logic        rf_we_o,
  output logic        flags_we_o,
  output logic [2:0]  state_o,
  output logic        fault_o,
  output logic [15:0] instr_count_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  // Wait-counter value seen in the last allowed waiting cycle: if the memory
  // still has not answered in this cycle, the counter would reach
  // MEM_TIMEOUT, so we trap. An acknowledge in this same cycle still wins.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] count_q, count_d;
  logic        retire;
  logic [2:0]  boundary;

  // Next-state and strobe decode. Strobes are combinational so that the
  // FETCH acknowledge can load IR and bump PC in the very cycle the memory
  // answers. The wait counter only survives while a handshake keeps waiting,
  // so it is naturally zero on every entry into FETCH or MEM.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    retire     = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_load_o  = 1'b0;
    pc_inc_o   = 1'b0;
    pc_load_o  = 1'b0;
    rf_we_o    = 1'b0;
    flags_we_o = 1'b0;
    boundary   = run_i ? S_FETCH : S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_load_o = 1'b1;
          pc_inc_o  = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = ig_ex_i ? boundary : S_EXEC;
      end
      S_EXEC: begin
        if (br_en_i) begin
          pc_load_o = 1'b1;
          retire    = 1'b1;
          state_d   = boundary;
        end else if (is_mem_i) begin
          state_d = S_MEM;
        end else begin
          rf_we_o    = write_rd_i;
          flags_we_o = s_i;
          retire     = 1'b1;
          state_d    = boundary;
        end
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = ~ld_i;
        if (mem_ready_i) begin
          if (ld_i) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = boundary;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we_o = 1'b1;
        retire  = 1'b1;
        state_d = boundary;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    count_d = retire ? count_q + 16'd1 : count_q;
  end

  // State registers; reset has priority over every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign state_o       = state_q;
  assign fault_o       = (state_q == S_FAULT);
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_sequencer
//
// Table-driven bench for exec_sequencer. Each record holds the inputs of one
// clock cycle and the outputs the sequencer must show during that cycle.
// Records are driven on the falling edge; the expected outputs go into a
// scoreboard queue and are popped and compared just after the inputs settle,
// well before the next rising edge. Hand-written sequences cover handshake
// timeouts, reset in the middle of a transfer and counter wrap.
// ---------------------------------------------------------------------------
module tb_exec_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  // Input bits: {rst, run, ig_ex, br_en, write_rd, S, is_mem, ld, mem_ready}
  localparam logic [8:0] RST = 9'b100000000;
  localparam logic [8:0] RUN = 9'b010000000;
  localparam logic [8:0] IG  = 9'b001000000;
  localparam logic [8:0] BR  = 9'b000100000;
  localparam logic [8:0] WR  = 9'b000010000;
  localparam logic [8:0] SF  = 9'b000001000;
  localparam logic [8:0] MEM = 9'b000000100;
  localparam logic [8:0] LD  = 9'b000000010;
  localparam logic [8:0] RDY = 9'b000000001;
  localparam logic [8:0] NONE = 9'b000000000;

  // Strobe bits: {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, rf_we, flags_we}
  localparam logic [7:0] NO  = 8'b0000_0000;
  localparam logic [7:0] FET = 8'b1001_1000;
  localparam logic [7:0] FW  = 8'b1000_0000;
  localparam logic [7:0] MRD = 8'b1010_0000;
  localparam logic [7:0] MWR = 8'b1110_0000;
  localparam logic [7:0] PCL = 8'b0000_0100;
  localparam logic [7:0] RFW = 8'b0000_0010;
  localparam logic [7:0] RFF = 8'b0000_0011;

  typedef struct {
    logic [8:0]  in;
    logic [2:0]  st;
    logic [7:0]  stb;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  stb;
    logic        flt;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, run, ig_ex, br_en, write_rd, s, is_mem, ld, mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, rf_we, flags_we;
  logic [2:0]  state;
  logic        fault;
  logic [15:0] instr_count;

  int compared   = 0;
  int mismatched = 0;
  int cycleNo    = 0;

  vec_t tbl[$];
  exp_t scoreboard[$];

  exec_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .ig_ex_i(ig_ex), .br_en_i(br_en),
    .write_rd_i(write_rd), .s_i(s), .is_mem_i(is_mem), .ld_i(ld),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .addr_sel_o(addr_sel), .ir_load_o(ir_load), .pc_inc_o(pc_inc),
    .pc_load_o(pc_load), .rf_we_o(rf_we), .flags_we_o(flags_we),
    .state_o(state), .fault_o(fault), .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [8:0] in, input logic [2:0] st,
                              input logic [7:0] stb, input logic [15:0] cnt);
    vec_t v;
    v.in = in; v.st = st; v.stb = stb; v.cnt = cnt;
    return v;
  endfunction

  task automatic compareField(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycleNo, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs they must produce.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    {rst, run, ig_ex, br_en, write_rd, s, is_mem, ld, mem_ready} = v.in;
    e.st  = v.st;
    e.stb = v.stb;
    e.flt = (v.st == S_FAULT);
    e.cnt = v.cnt;
    scoreboard.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard at cycle %0d: got empty queue, expected an entry", cycleNo);
    end else begin
      e = scoreboard.pop_front();
      compareField("state", 16'(state), 16'(e.st));
      compareField("strobes",
                   16'({mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, rf_we, flags_we}),
                   16'(e.stb));
      compareField("fault", 16'(fault), 16'(e.flt));
      compareField("instr_count", instr_count, e.cnt);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput();
    cycleNo++;
  endtask

  initial begin
    {rst, run, ig_ex, br_en, write_rd, s, is_mem, ld, mem_ready} = RST;
    repeat (2) @(posedge clk);

    // ADD, branch, LDR with 3 wait cycles, STR with 1, skipped instruction,
    // run dropped mid-instruction, short fetch wait.
    tbl.push_back(mk(RDY,              S_IDLE,   NO,  16'd0));
    tbl.push_back(mk(RUN|RDY,          S_IDLE,   NO,  16'd0));
    tbl.push_back(mk(RUN|RDY,          S_FETCH,  FET, 16'd0));
    tbl.push_back(mk(RUN|WR|SF|RDY,    S_DECODE, NO,  16'd0));
    tbl.push_back(mk(RUN|WR|SF|RDY,    S_EXEC,   RFF, 16'd0));
    tbl.push_back(mk(RUN|RDY,          S_FETCH,  FET, 16'd1));
    tbl.push_back(mk(RUN|BR,           S_DECODE, NO,  16'd1));
    tbl.push_back(mk(RUN|BR,           S_EXEC,   PCL, 16'd1));
    tbl.push_back(mk(RUN|RDY,          S_FETCH,  FET, 16'd2));
    tbl.push_back(mk(RUN|MEM|LD,       S_DECODE, NO,  16'd2));
    tbl.push_back(mk(RUN|MEM|LD|WR,    S_EXEC,   NO,  16'd2));
    tbl.push_back(mk(RUN|LD,           S_MEM,    MRD, 16'd2));
    tbl.push_back(mk(RUN|LD,           S_MEM,    MRD, 16'd2));
    tbl.push_back(mk(RUN|LD,           S_MEM,    MRD, 16'd2));
    tbl.push_back(mk(RUN|LD|RDY,       S_MEM,    MRD, 16'd2));
    tbl.push_back(mk(RUN,              S_WB,     RFW, 16'd2));
    tbl.push_back(mk(RUN|RDY,          S_FETCH,  FET, 16'd3));
    tbl.push_back(mk(RUN|MEM,          S_DECODE, NO,  16'd3));
    tbl.push_back(mk(RUN|MEM,          S_EXEC,   NO,  16'd3));
    tbl.push_back(mk(RUN,              S_MEM,    MWR, 16'd3));
    tbl.push_back(mk(RUN|RDY,          S_MEM,    MWR, 16'd3));
    tbl.push_back(mk(RUN|RDY,          S_FETCH,  FET, 16'd4));
    tbl.push_back(mk(RUN|IG|WR|SF|BR,  S_DECODE, NO,  16'd4));
    tbl.push_back(mk(RUN|BR|MEM|RDY,   S_FETCH,  FET, 16'd4));
    tbl.push_back(mk(WR,               S_DECODE, NO,  16'd4));
    tbl.push_back(mk(WR,               S_EXEC,   RFW, 16'd4));
    tbl.push_back(mk(NONE,             S_IDLE,   NO,  16'd5));
    tbl.push_back(mk(RUN,              S_IDLE,   NO,  16'd5));
    tbl.push_back(mk(RUN,              S_FETCH,  FW,  16'd5));
    tbl.push_back(mk(RUN|RDY,          S_FETCH,  FET, 16'd5));
    tbl.push_back(mk(NONE,             S_DECODE, NO,  16'd5));
    tbl.push_back(mk(NONE,             S_EXEC,   NO,  16'd5));
    tbl.push_back(mk(NONE,             S_IDLE,   NO,  16'd6));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Fetch acknowledged in its 15th cycle: no fault.
    step(mk(RUN, S_IDLE, NO, 16'd6));
    for (int i = 0; i < 14; i++) step(mk(RUN, S_FETCH, FW, 16'd6));
    step(mk(RUN|RDY, S_FETCH,  FET, 16'd6));
    step(mk(IG,      S_DECODE, NO,  16'd6));
    step(mk(NONE,    S_IDLE,   NO,  16'd6));

    // Reset in the middle of a load handshake, together with run and ack.
    step(mk(RUN,           S_IDLE,   NO,  16'd6));
    step(mk(RUN|RDY,       S_FETCH,  FET, 16'd6));
    step(mk(RUN|MEM|LD,    S_DECODE, NO,  16'd6));
    step(mk(RUN|MEM|LD,    S_EXEC,   NO,  16'd6));
    step(mk(RUN|LD,        S_MEM,    MRD, 16'd6));
    step(mk(RST|RUN|LD|RDY, S_MEM,   MRD, 16'd6));
    step(mk(RUN|RDY,       S_IDLE,   NO,  16'd0));
    step(mk(RUN|RDY,       S_FETCH,  FET, 16'd0));
    step(mk(IG,            S_DECODE, NO,  16'd0));

    // Counter wrap: preset to FFFF while idle, then retire one ADD.
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.count_q;
    step(mk(RUN,     S_IDLE,   NO, 16'hFFFF));
    step(mk(RUN|RDY, S_FETCH,  FET, 16'hFFFF));
    step(mk(NONE,    S_DECODE, NO, 16'hFFFF));
    step(mk(NONE,    S_EXEC,   NO, 16'hFFFF));
    step(mk(NONE,    S_IDLE,   NO, 16'h0000));

    // Fetch never acknowledged: fault after 15 wait cycles, sticky until reset.
    step(mk(RUN, S_IDLE, NO, 16'd0));
    for (int i = 0; i < 15; i++) step(mk(RUN, S_FETCH, FW, 16'd0));
    for (int i = 0; i < 3; i++) step(mk(RUN|RDY, S_FAULT, NO, 16'd0));
    step(mk(RST|RUN|RDY, S_FAULT, NO, 16'd0));
    step(mk(NONE,        S_IDLE,  NO, 16'd0));

    // Store never acknowledged: same timeout from the data phase.
    step(mk(RUN,     S_IDLE,   NO,  16'd0));
    step(mk(RUN|RDY, S_FETCH,  FET, 16'd0));
    step(mk(RUN|MEM, S_DECODE, NO,  16'd0));
    step(mk(RUN|MEM, S_EXEC,   NO,  16'd0));
    for (int i = 0; i < 15; i++) step(mk(RUN, S_MEM, MWR, 16'd0));
    step(mk(RUN|RDY, S_FAULT, NO, 16'd0));
    step(mk(RST,     S_FAULT, NO, 16'd0));
    step(mk(NONE,    S_IDLE,  NO, 16'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max cycles a memory wait may last before fault (range 1..255).
REQ-002 clk  in  1  core clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 run  in  1  start/continue request, sampled only at instruction boundaries.
REQ-005 ig_ex  in  1  decoder: skip current instruction.
REQ-006 br_en  in  1  decoder: branch (B/BX/ERET) to execute.
REQ-007 write_rd  in  1  decoder: result register write required.
REQ-008 S  in  1  decoder: update condition flags.
REQ-009 is_mem  in  1  decoder: single data transfer instruction.
REQ-010 ld  in  1  decoder: transfer is load (1) or store (0).
REQ-011 mem_ready  in  1  memory handshake acknowledge.
REQ-012 mem_req  out  1  memory request, held until acknowledged.
REQ-013 mem_we  out  1  memory write strobe (store).
REQ-014 addr_sel  out  1  memory address source: 0 = PC, 1 = data address.
REQ-015 ir_load  out  1  load fetched word into IR.
REQ-016 pc_inc  out  1  PC += 4.
REQ-017 pc_load  out  1  PC <= branch target.
REQ-018 rf_we  out  1  register file write enable.
REQ-019 flags_we  out  1  NZCV write enable.
REQ-020 state  out  3  current state code.
REQ-021 fault  out  1  sticky memory-timeout fault.
REQ-022 instr_count  out  16  retired-instruction counter.

Function
REQ-023 States/codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7; code 6 unused, SHALL go to IDLE.
REQ-024 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-025 FETCH: mem_req=1, addr_sel=0, mem_we=0; in cycle mem_ready=1: ir_load=1, pc_inc=1 (same cycle), next DECODE.
REQ-026 DECODE: exactly one cycle, no strobes; ig_ex=1 -> boundary (REQ-031), no count; else -> EXEC.
REQ-027 EXEC, br_en=1: pc_load=1 one cycle, retire.
REQ-028 EXEC, br_en=0, is_mem=1: -> MEM, no strobes.
REQ-029 EXEC, otherwise: rf_we=write_rd, flags_we=S, one cycle, retire.
REQ-030 MEM: mem_req=1, addr_sel=1, mem_we=!ld; on mem_ready=1: ld=1 -> WB, ld=0 -> retire.
REQ-031 WB: rf_we=1 one cycle, retire; "retire" = instr_count+1 then boundary; boundary: run=1 -> FETCH, run=0 -> IDLE.
REQ-032 Decoder inputs sampled only in DECODE/EXEC/MEM as stated; changes elsewhere ignored.
REQ-033 Wait counter (8-bit) cleared on entering FETCH or MEM, increments each cycle mem_ready=0; reaching MEM_TIMEOUT -> FAULT next cycle.
REQ-034 mem_ready=1 in the same cycle counter reaches MEM_TIMEOUT: acknowledge wins, no fault.
REQ-035 FAULT: fault=1, all strobes 0, exited only by rst.
REQ-036 instr_count wraps 16'hFFFF -> 16'h0000.
REQ-037 run deasserted mid-instruction: instruction completes, then IDLE.
REQ-038 rf_we, pc_load, pc_inc, ir_load never asserted more than one cycle per instruction.

Reset
REQ-039 rst=1 at any clock edge, any state (incl. mid-handshake): state=IDLE, all outputs 0, instr_count=0, wait counter=0, fault=0 next cycle.
REQ-040 rst dominates run and mem_ready in the same cycle.

Verification
REQ-041 ADD, run=1, mem_ready tied 1: states 1,2,3,1; ir_load/pc_inc at cycle 1, rf_we=1 at EXEC, instr_count=1.
REQ-042 LDR (is_mem=1, ld=1), mem_ready delayed 3 cycles in MEM: mem_req held 4 cycles, addr_sel=1, mem_we=0, then WB rf_we=1, count+1.
REQ-043 STR (ld=0): MEM mem_we=1 until ack, no WB, no rf_we.
REQ-044 ig_ex=1 in DECODE: back to FETCH, no rf_we/flags_we/pc_load, instr_count unchanged.
REQ-045 mem_ready held 0 in FETCH, MEM_TIMEOUT=15: FAULT after 15 wait cycles, fault=1 until rst; ack on 15th cycle -> DECODE, fault=0.
REQ-046 instr_count preset to 16'hFFFF by 65535 retires (or forced), one more retire -> 0; rst asserted in MEM -> IDLE, mem_req=0 next cycle.
